// File: rtl/tensor_hmma_arbiter.sv
// tensor_hmma_arbiter
//   Shares one tensor threadgroup pair among NUM_REQS warp requesters.
//   A granted warp keeps the operand path for a full NUM_STEPS-beat HMMA
//   burst. Grants rotate round-robin. A credit counter caps the number of
//   tiles that have been issued and not yet returned. Returned results are
//   steered to the owning warp by wid.
// Ports
//   clk, reset        clock, synchronous active-low reset
//   req_valid/ready   per-warp beat handshake
//   req_data          per-warp tile beat, NUM_REQS x DATAW (warp i at i*DATAW)
//   tc_valid/ready    beat handshake toward the tensor unit
//   tc_data, tc_wid   muxed beat and its warp id
//   rsp_valid_in/ready_in, rsp_wid_in  result handshake from the tensor unit
//   rsp_valid/ready   per-warp result handshake (combinational demux)
//   busy              burst in progress or tiles in flight
//   err               sticky protocol error
module tensor_hmma_arbiter #(
  parameter int NUM_REQS     = 4,
  parameter int NUM_STEPS    = 4,
  parameter int DATAW        = 1536,
  parameter int MAX_INFLIGHT = 8,
  parameter int WIDW         = $clog2(NUM_REQS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       req_valid,
  output logic [NUM_REQS-1:0]       req_ready,
  input  logic [NUM_REQS*DATAW-1:0] req_data,
  output logic                      tc_valid,
  input  logic                      tc_ready,
  output logic [DATAW-1:0]          tc_data,
  output logic [WIDW-1:0]           tc_wid,
  input  logic                      rsp_valid_in,
  output logic                      rsp_ready_in,
  input  logic [WIDW-1:0]           rsp_wid_in,
  output logic [NUM_REQS-1:0]       rsp_valid,
  input  logic [NUM_REQS-1:0]       rsp_ready,
  output logic                      busy,
  output logic                      err
);

  localparam int STEPW = $clog2(NUM_STEPS + 1);
  localparam int INFW  = $clog2(MAX_INFLIGHT + 1);

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  state_t            state_q, state_d;
  logic [WIDW-1:0]   grant_q, grant_d;
  logic [STEPW-1:0]  step_q, step_d;
  logic [WIDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [INFW-1:0]   inflight_q, inflight_d;
  logic              err_q, err_d;

  logic              can_issue;
  logic              tc_fire;
  logic              rsp_fire;
  logic              wid_bad;
  logic [WIDW-1:0]   next_ptr;
  logic [WIDW:0]     pick_idle;
  logic [WIDW:0]     pick_next;

  // Returns {found, index} of the first set bit at or after start, wrapping.
  function automatic logic [WIDW:0] rr_pick(input logic [NUM_REQS-1:0] vec,
                                            input logic [WIDW-1:0]     start);
    logic            found;
    logic [WIDW-1:0] win;
    logic [WIDW-1:0] idx;
    found = 1'b0;
    win   = '0;
    for (int unsigned k = 0; k < NUM_REQS; k++) begin
      idx = WIDW'((32'(start) + k) % NUM_REQS);
      if (!found && vec[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    return {found, win};
  endfunction

  // Out-of-range warp ids are only possible when NUM_REQS is not a power of two.
  if (NUM_REQS == (1 << WIDW)) begin : g_pow2
    assign wid_bad = 1'b0;
  end else begin : g_npow2
    assign wid_bad = (32'(rsp_wid_in) >= NUM_REQS);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      step_q     <= '0;
      rr_ptr_q   <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      step_q     <= step_d;
      rr_ptr_q   <= rr_ptr_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    step_d     = step_q;
    rr_ptr_d   = rr_ptr_q;
    inflight_d = inflight_q;
    next_ptr   = WIDW'((32'(grant_q) + 1) % NUM_REQS);
    pick_idle  = rr_pick(req_valid, rr_ptr_q);
    // The finishing warp is masked so a waiting peer always takes the next burst.
    pick_next  = rr_pick(req_valid & ~(NUM_REQS'(1) << grant_q), next_ptr);

    case (state_q)
      ST_IDLE: begin
        if (pick_idle[WIDW]) begin
          grant_d = pick_idle[WIDW-1:0];
          step_d  = '0;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        if (tc_fire) begin
          if (step_q == STEPW'(NUM_STEPS - 1)) begin
            rr_ptr_d = next_ptr;
            step_d   = '0;
            if (pick_next[WIDW]) begin
              grant_d = pick_next[WIDW-1:0];
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            step_d = step_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    case ({tc_fire, rsp_fire})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   if (inflight_q != '0) inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase

    err_d = err_q | (rsp_fire && (inflight_q == '0)) | (rsp_valid_in && wid_bad);
  end

  always_comb begin
    can_issue = (inflight_q < INFW'(MAX_INFLIGHT));
    req_ready = '0;
    tc_valid  = 1'b0;
    if (state_q == ST_BURST) begin
      tc_valid           = req_valid[grant_q] && can_issue;
      req_ready[grant_q] = tc_ready && can_issue;
    end
    tc_fire = tc_valid && tc_ready;
    tc_wid  = grant_q;
    tc_data = req_data[grant_q*DATAW +: DATAW];

    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      rsp_valid[i] = rsp_valid_in && (rsp_wid_in == WIDW'(i));
    end
    rsp_ready_in = !wid_bad && rsp_ready[rsp_wid_in];
    rsp_fire     = rsp_valid_in && rsp_ready_in;

    busy = (state_q == ST_BURST) || (inflight_q != '0);
  end

  assign err = err_q;

endmodule

// File: doc/tensor_hmma_arbiter.md
Name: tensor_hmma_arbiter

Overview:
- Shares one tensor threadgroup pair (operand-buffer input plus warp-id-tagged result output) among NUM_REQS warp requesters.
- Each HMMA instruction is NUM_STEPS consecutive tile beats from one warp. The arbiter locks a warp for its whole burst, grants warps round-robin, and limits in-flight tiles with a credit counter.
- Results coming back from the tensor unit are demultiplexed to the owning warp by wid.
- Sits between the per-warp tensor issue queues and the threadgroup datapath.

Parameters:
- NUM_REQS, 4, number of requesting warps; requester index equals wid; power of two ≥ 2.
- NUM_STEPS, 4, tile beats per HMMA burst; ≥ 1.
- DATAW, 1536, width of one tile beat (A + B + C tiles).
- MAX_INFLIGHT, 8, maximum tiles issued and not yet returned; must be ≤ the downstream wid queue depth.
- WIDW, $clog2(NUM_REQS), warp-id width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (0 = reset asserted)
- req_valid  in  NUM_REQS  per-warp beat valid
- req_ready  out  NUM_REQS  per-warp beat accepted
- req_data  in  NUM_REQS×DATAW  per-warp tile beat
- tc_valid  out  1  beat to tensor unit
- tc_ready  in  1  tensor unit ready_in
- tc_data  out  DATAW  muxed beat
- tc_wid  out  WIDW  granted warp
- rsp_valid_in  in  1  tensor unit result valid
- rsp_ready_in  out  1  result accepted
- rsp_wid_in  in  WIDW  result warp id (D_wid)
- rsp_valid  out  NUM_REQS  per-warp result valid
- rsp_ready  in  NUM_REQS  per-warp result ready
- busy  out  1  burst in progress or inflight ≠ 0
- err  out  1  sticky protocol error

Behaviour:
- State
  - FSM: IDLE, BURST.
  - Registers: grant (WIDW), step (clog2(NUM_STEPS+1)), rr_ptr (WIDW), inflight (clog2(MAX_INFLIGHT+1)), err.
- Reset (reset==0 at a clock edge)
  - state=IDLE, grant=0, step=0, rr_ptr=0, inflight=0, err=0.
  - Outputs are then req_ready=0, tc_valid=0, busy=0, rsp_valid=0, err=0.
  - Reset mid-burst abandons the burst. Results still in flight must not be presented after reset; if one is, err is set.
- IDLE
  - Outputs tc_valid=0 and req_ready=0.
  - If any req_valid is set, pick the first set bit searching from rr_ptr upward with wrap. Register it as grant, set step=0, go to BURST.
  - Arbitration costs one cycle: the first beat fires no earlier than the cycle after req_valid rises.
- BURST
  - tc_valid = req_valid[grant] && (inflight < MAX_INFLIGHT).
  - tc_data = req_data[grant]; tc_wid = grant.
  - req_ready[grant] = tc_ready && (inflight < MAX_INFLIGHT); every other req_ready is 0.
  - A fire is tc_valid && tc_ready; each fire increments step.
  - Other warps' valids are ignored until the burst ends; a burst is never preempted.
- Last beat (fire while step==NUM_STEPS-1)
  - Set rr_ptr = grant+1 (mod NUM_REQS).
  - Re-arbitrate in the same cycle over req_valid with bit grant masked, searching from grant+1.
  - If a winner exists: grant=winner, step=0, stay in BURST. There is no bubble between back-to-back bursts of different warps.
  - Otherwise go to IDLE.
  - The finishing warp can win the next burst only through IDLE. It never wins the same-cycle re-arbitration, so other waiting warps get the next burst.
- Credits
  - inflight +1 on tc fire; −1 on result fire (rsp_valid_in && rsp_ready_in); unchanged when both happen in one cycle.
  - When inflight==MAX_INFLIGHT, tc_valid and req_ready are held 0 while the burst and step are held.
- Response demux (combinational)
  - rsp_valid[i] = rsp_valid_in && (rsp_wid_in==i).
  - rsp_ready_in = rsp_ready[rsp_wid_in].
  - Zero latency, no buffering.
- err is sticky and set by either:
  - a result fire while inflight==0 (inflight stays 0, no underflow);
  - rsp_wid_in ≥ NUM_REQS while rsp_valid_in (non-power-of-two builds only).
- busy = (state==BURST) || (inflight≠0).
- Requester obligation: after raising req_valid a requester holds its data until req_ready. The arbiter does not check this.

Test Plan:
- Reset, then warp 2 raises valid with 4 beats, tc_ready=1 → grant=2 one cycle later; 4 consecutive fires with tc_wid=2; then IDLE, rr_ptr=3, inflight=4.
- Warps 0,1,3 all valid with rr_ptr=0, tc_ready=1 → bursts in order 0,1,3, each 4 beats, no idle cycle between bursts; 12 fires in 13 cycles.
- MAX_INFLIGHT=8, no responses, warps 0 and 1 each issue 4 beats → after 8 fires tc_valid=0 and req_ready=0. One result with wid=0 → inflight=7 and the next beat fires the following cycle.
- tc_ready toggling 1,0,1,0 during warp 1's burst → step advances only on fire cycles, req_ready[1] tracks tc_ready, other warps stay unserved until step 3 fires.
- Result with wid=3 and rsp_ready=4'b0111 → rsp_valid=4'b1000 and rsp_ready_in=0. Then rsp_ready[3]=1 → fire and inflight decrements. A fire in the same cycle as a tc fire leaves inflight unchanged.
- Result fire with inflight=0 → err=1 and stays 1, inflight stays 0. Reset asserted (0) mid-burst at step 2 → next cycle IDLE, inflight=0, err=0, req_ready=0.
